// File: rtl/decode_issue_buffer_pkg.sv
// Shared types for the ID->EXE issue buffer: FSM encodings,
// decoded-bundle field layout and the serialising ALU opcodes.
package decode_issue_buffer_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_NOTIFY = 2'd3
    } dib_state_e;

    localparam int BUNDLE_W_DEF = 160;

    // Bundle layout, LSB offsets and widths
    localparam int INSTR_LSB = 128;
    localparam int INSTR_W   = 32;
    localparam int PC_LSB    = 96;
    localparam int PC_W      = 32;
    localparam int OPA_LSB   = 64;
    localparam int OPA_W     = 32;
    localparam int OPB_LSB   = 32;
    localparam int OPB_W     = 32;
    localparam int REGS_LSB  = 17;
    localparam int REGS_W    = 15;
    localparam int CTRL_LSB  = 0;
    localparam int CTRL_W    = 17;
    localparam int ALU_LSB   = 0;
    localparam int ALU_W     = 6;

    localparam logic [5:0] ALU_LL = 6'b101000;
    localparam logic [5:0] ALU_SC = 6'b110110;

    // ID uses this to raise in_serial for LL/SC
    function automatic logic is_llsc(input logic [5:0] alu);
        return (alu == ALU_LL) || (alu == ALU_SC);
    endfunction

endpackage

// File: rtl/decode_issue_buffer_if.sv
// ID->buffer->EXE handshake bundle.
// slave: buffer side; master: ID/EXE (or bench) side.
interface decode_issue_buffer_if
    import decode_issue_buffer_pkg::*;
#(
    parameter int BUNDLE_W = BUNDLE_W_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic [BUNDLE_W-1:0] in_bundle;
    logic                in_serial;
    logic                in_sys;
    logic                out_valid;
    logic                out_ready;
    logic [BUNDLE_W-1:0] out_bundle;

    modport slave (
        input  in_valid, in_bundle, in_serial, in_sys, out_ready,
        output in_ready, out_valid, out_bundle
    );

    modport master (
        output in_valid, in_bundle, in_serial, in_sys, out_ready,
        input  in_ready, out_valid, out_bundle
    );
endinterface

// File: rtl/decode_issue_buffer_issue_fifo_core.sv
// DEPTH-entry FIFO storage, pointers and occupancy.
// Ports: enq_i/deq_i/flush_i, wdata_i -> rdata_o, valid_o, count_o.
module issue_fifo_core
    import decode_issue_buffer_pkg::*;
#(
    parameter  int BUNDLE_W = BUNDLE_W_DEF,
    parameter  int DEPTH    = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                enq_i,
    input  logic                deq_i,
    input  logic                flush_i,
    input  logic [BUNDLE_W-1:0] wdata_i,
    output logic [BUNDLE_W-1:0] rdata_o,
    output logic                valid_o,
    output logic [CNT_W-1:0]    count_o
);

    logic [BUNDLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Explicit wrap so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = wr_q;
            cnt_d = '0;
        end else begin
            if (enq_i) wr_d = bump(wr_q);
            if (deq_i) rd_d = bump(rd_q);
            if (enq_i && !deq_i)
                cnt_d = cnt_q + CNT_W'(1);
            else if (!enq_i && deq_i)
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge CLK) begin
        if (enq_i && !flush_i)
            mem[wr_q] <= wdata_i;
    end

    assign valid_o = (cnt_q != '0);
    assign rdata_o = valid_o ? mem[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/decode_issue_buffer.sv
// ID->EXE decoupling buffer with serialisation FSM (drain, bubbles, SYS).
// Ports: CLK, RESET, bus (slave), flush, SYS, WANT_FREEZE, count, state.
module decode_issue_buffer
    import decode_issue_buffer_pkg::*;
#(
    parameter  int BUNDLE_W = BUNDLE_W_DEF,
    parameter  int DEPTH    = 4,
    parameter  int BUBBLES  = 3,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    decode_issue_buffer_if.slave  bus,
    input  logic                  flush,
    output logic                  SYS,
    output logic                  WANT_FREEZE,
    output logic [CNT_W-1:0]      count,
    output logic [1:0]            state
);

    localparam int BUB_W = $clog2(BUBBLES + 1);

    dib_state_e       state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic             sys_pend_q, sys_pend_d;
    logic             in_rdy;
    logic             enq;
    logic             deq;

    // Gated by RESET so ID sees not-ready while held in reset
    assign in_rdy = RESET
                  & (state_q == ST_RUN)
                  & (count < CNT_W'(DEPTH))
                  & ~flush;

    assign bus.in_ready = in_rdy;
    assign enq          = bus.in_valid & in_rdy;
    assign deq          = bus.out_valid & bus.out_ready;
    assign WANT_FREEZE  = bus.in_valid & ~in_rdy;

    issue_fifo_core #(
        .BUNDLE_W (BUNDLE_W),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .enq_i   (enq),
        .deq_i   (deq),
        .flush_i (flush),
        .wdata_i (bus.in_bundle),
        .rdata_o (bus.out_bundle),
        .valid_o (bus.out_valid),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        bub_d      = bub_q;
        sys_pend_d = sys_pend_q;
        if (flush) begin
            state_d    = ST_RUN;
            bub_d      = '0;
            sys_pend_d = 1'b0;
        end else begin
            unique case (1'b1)
                (state_q == ST_RUN): begin
                    if (enq && bus.in_serial) begin
                        state_d    = ST_DRAIN;
                        sys_pend_d = bus.in_sys;
                    end
                end
                (state_q == ST_DRAIN): begin
                    // Last entry leaving this cycle counts as drained
                    if (count == '0 ||
                        (count == CNT_W'(1) && deq)) begin
                        state_d = ST_BUBBLE;
                        bub_d   = BUB_W'(BUBBLES);
                    end
                end
                (state_q == ST_BUBBLE): begin
                    bub_d = bub_q - BUB_W'(1);
                    if (bub_q <= BUB_W'(1)) begin
                        bub_d   = '0;
                        state_d = sys_pend_q ? ST_NOTIFY : ST_RUN;
                    end
                end
                (state_q == ST_NOTIFY): begin
                    sys_pend_d = 1'b0;
                    state_d    = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_RUN;
            bub_q      <= '0;
            sys_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bub_q      <= bub_d;
            sys_pend_q <= sys_pend_d;
        end
    end

    assign SYS   = (state_q == ST_NOTIFY);
    assign state = state_q;

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed bench for decode_issue_buffer: DEPTH=4 and DEPTH=3 instances.
// Streams, backpressure, syscall/LL serialisation, flush, wrap, reset.
module tb_decode_issue_buffer;
    import decode_issue_buffer_pkg::*;

    localparam int BW = 160;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    decode_issue_buffer_if #(.BUNDLE_W(BW)) if4 ();
    decode_issue_buffer_if #(.BUNDLE_W(BW)) if3 ();

    logic       flush4, flush3;
    logic       sys4, sys3;
    logic       wf4, wf3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;
    logic [1:0] st4, st3;

    decode_issue_buffer #(
        .BUNDLE_W (BW),
        .DEPTH    (4),
        .BUBBLES  (3)
    ) u_dut4 (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (if4),
        .flush       (flush4),
        .SYS         (sys4),
        .WANT_FREEZE (wf4),
        .count       (cnt4),
        .state       (st4)
    );

    decode_issue_buffer #(
        .BUNDLE_W (BW),
        .DEPTH    (3),
        .BUBBLES  (3)
    ) u_dut3 (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (if3),
        .flush       (flush3),
        .SYS         (sys3),
        .WANT_FREEZE (wf3),
        .count       (cnt3),
        .state       (st3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] exp_t3 [8] = '{2'd1, 2'd1, 2'd1, 2'd2,
                               2'd2, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp_t4 [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};

    task automatic chk(input string tag,
                       input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int k);
        return {5{32'hA5A5_0000 ^ 32'(k)}};
    endfunction

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RESET = 1'b0;
        flush4 = 1'b0;
        flush3 = 1'b0;
        if4.in_valid = 1'b0; if4.in_bundle = '0;
        if4.in_serial = 1'b0; if4.in_sys = 1'b0;
        if4.out_ready = 1'b0;
        if3.in_valid = 1'b0; if3.in_bundle = '0;
        if3.in_serial = 1'b0; if3.in_sys = 1'b0;
        if3.out_ready = 1'b0;

        // Reset state
        tick;
        chk("rst_cnt", cnt4, 0);
        chk("rst_st", st4, 0);
        chk("rst_sys", sys4, 0);
        chk("rst_oval", if4.out_valid, 0);
        chk("rst_obun", if4.out_bundle, 0);
        chk("rst_rdy", if4.in_ready, 0);
        RESET = 1'b1;
        tick;

        // 1: streaming, latency 1, count<=1
        if4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if4.in_valid  = 1'b1;
            if4.in_bundle = mk(i);
            #1;
            chk("t1_rdy", if4.in_ready, 1);
            if (i > 0) begin
                chk("t1_out", if4.out_bundle, mk(i - 1));
                chk("t1_cnt", cnt4, 1);
            end
            chk("t1_sys", sys4, 0);
            tick;
        end
        if4.in_valid = 1'b0;
        #1;
        chk("t1_last", if4.out_bundle, mk(7));
        tick;
        #1;
        chk("t1_cnt0", cnt4, 0);
        chk("t1_oval0", if4.out_valid, 0);
        chk("t1_obun0", if4.out_bundle, 0);

        // 2: backpressure, full, no bypass, order
        if4.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if4.in_valid  = 1'b1;
            if4.in_bundle = mk(10 + i);
            #1;
            chk("t2_rdy", if4.in_ready, (i < 4));
            chk("t2_wf", wf4, (i == 4));
            tick;
        end
        #1;
        chk("t2_cnt4", cnt4, 4);
        if4.out_ready = 1'b1;
        #1;
        chk("t2_nobyp", if4.in_ready, 0);
        chk("t2_out0", if4.out_bundle, mk(10));
        tick;
        if4.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t2_ord", if4.out_bundle, mk(10 + i));
            tick;
        end
        #1;
        chk("t2_cnt0", cnt4, 0);

        // 3: syscall behind two bundles
        if4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if4.in_valid  = 1'b1;
            if4.in_bundle = mk(20 + i);
            if4.in_serial = (i == 2);
            if4.in_sys    = (i == 2);
            tick;
        end
        if4.in_valid  = 1'b0;
        if4.in_serial = 1'b0;
        if4.in_sys    = 1'b0;
        #1;
        chk("t3_st", st4, 1);
        chk("t3_cnt", cnt4, 3);
        chk("t3_rdy", if4.in_ready, 0);
        if4.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t3_seq_st", st4, exp_t3[c]);
            chk("t3_seq_sys", sys4, (c == 6));
            chk("t3_seq_rdy", if4.in_ready, (c == 7));
            if (c < 3)
                chk("t3_seq_out", if4.out_bundle, mk(20 + c));
            tick;
        end

        // 4: LL, same timing, no SYS
        if4.in_valid  = 1'b1;
        if4.in_bundle = mk(30);
        if4.in_serial = 1'b1;
        if4.in_sys    = 1'b0;
        tick;
        if4.in_valid  = 1'b0;
        if4.in_serial = 1'b0;
        #1;
        chk("t4_out", if4.out_bundle, mk(30));
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_st", st4, exp_t4[c]);
            chk("t4_sys", sys4, 0);
            tick;
        end

        // 5: flush during DRAIN with count=3
        if4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if4.in_valid  = 1'b1;
            if4.in_bundle = mk(40 + i);
            if4.in_serial = (i == 2);
            if4.in_sys    = (i == 2);
            tick;
        end
        if4.in_valid  = 1'b0;
        if4.in_serial = 1'b0;
        if4.in_sys    = 1'b0;
        #1;
        chk("t5_cnt3", cnt4, 3);
        chk("t5_st1", st4, 1);
        flush4 = 1'b1;
        #1;
        chk("t5_rdyf", if4.in_ready, 0);
        tick;
        flush4 = 1'b0;
        #1;
        chk("t5_cnt0", cnt4, 0);
        chk("t5_st0", st4, 0);
        chk("t5_rdy", if4.in_ready, 1);
        chk("t5_oval", if4.out_valid, 0);
        for (int c = 0; c < 5; c++) begin
            chk("t5_nosys", sys4, 0);
            tick;
        end

        // 6: DEPTH=3 wrap, simultaneous enq/deq at count=2
        if3.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if3.in_valid  = 1'b1;
            if3.in_bundle = mk(50 + k);
            tick;
        end
        if3.out_ready = 1'b1;
        for (int k = 2; k < 10; k++) begin
            if3.in_valid  = 1'b1;
            if3.in_bundle = mk(50 + k);
            #1;
            chk("t6_cnt2", cnt3, 2);
            chk("t6_rdy", if3.in_ready, 1);
            chk("t6_out", if3.out_bundle, mk(50 + k - 2));
            tick;
        end
        if3.in_valid = 1'b0;
        for (int k = 8; k < 10; k++) begin
            #1;
            chk("t6_tail", if3.out_bundle, mk(50 + k));
            tick;
        end
        #1;
        chk("t6_cnt0", cnt3, 0);

        // Reset in the middle of a bubble window
        if3.in_valid  = 1'b1;
        if3.in_bundle = mk(60);
        if3.in_serial = 1'b1;
        if3.in_sys    = 1'b1;
        tick;
        if3.in_valid  = 1'b0;
        if3.in_serial = 1'b0;
        if3.in_sys    = 1'b0;
        #1;
        chk("t6_drain", st3, 1);
        tick;
        #1;
        chk("t6_bub", st3, 2);
        RESET = 1'b0;
        #1;
        chk("t6_r_st", st3, 0);
        chk("t6_r_sys", sys3, 0);
        chk("t6_r_cnt", cnt3, 0);
        chk("t6_r_oval", if3.out_valid, 0);
        chk("t6_r_obun", if3.out_bundle, 0);
        chk("t6_r_rdy", if3.in_ready, 0);
        tick;
        RESET = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("t6_nosys", sys3, 0);
            chk("t6_run", st3, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
